shift_tx_ctrl: RTL and testbench

SHIFT_TX_CTRL -- requirements
Module: shift_tx_ctrl

---
 rtl/shift_tx_pkg.sv | 23 ++
 rtl/shiftr_reg.sv | 27 ++
 rtl/shift_tx_ctrl.sv | 139 +++++++++++++
 tb/tb_shift_tx_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_tx_pkg.sv
// Shared types and constants for the serial transmitter.
// Define SHIFT_TX_PARITY_EN to add the parity state.
package shift_tx_pkg;

`ifdef SHIFT_TX_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PAR,
    ST_DONE
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;
`endif

  // Level driven on the serial line whenever no data or parity bit is on it.
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/shiftr_reg.sv
// Right-shift register with parallel load; bit 0 is the serial output.
module shiftr_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             si_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             lsb_o
);

  logic [WIDTH-1:0] sr_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (en_i) begin
      sr_q <= load_i ? d_i : {si_i, sr_q[WIDTH-1:1]};
    end
  end

  assign lsb_o = sr_q[0];

endmodule

// File: rtl/shift_tx_ctrl.sv
// Parallel-to-serial transmitter, LSB first, DIV clocks per bit, one-cycle done pulse.
// Define SHIFT_TX_PARITY_EN to append an even-parity bit after the data bits.
module shift_tx_ctrl
  import shift_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             so
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             load;
  logic             shift_en;
  logic             div_wrap;
  logic             sr_lsb;

  assign div_wrap = (div_cnt_q == DIV_LAST);

  // NOTE: asynchronous reset brings the line to idle immediately, even without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

`ifdef SHIFT_TX_PARITY_EN
  logic parity_q;

  // Parity is taken from din at acceptance so later din changes cannot leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ^din;
    end
  end
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    so        = IDLE_LEVEL;

    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          load      = 1'b1;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        busy = 1'b1;
        so   = sr_lsb;
        if (div_wrap) begin
          div_cnt_d = '0;
          shift_en  = 1'b1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_LAST) begin
`ifdef SHIFT_TX_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_DONE;
`endif
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

`ifdef SHIFT_TX_PARITY_EN
      ST_PAR: begin
        busy = 1'b1;
        so   = parity_q;
        if (div_wrap) begin
          div_cnt_d = '0;
          state_d   = ST_DONE;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
`endif

      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  shiftr_reg #(
    .WIDTH(WIDTH)
  ) u_shiftr (
    .clk   (clk),
    .rst   (rst),
    .load_i(load),
    .en_i  (load | shift_en),
    .si_i  (1'b0),
    .d_i   (din),
    .lsb_o (sr_lsb)
  );

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Self-checking bench for shift_tx_ctrl: one DIV=4 instance and one DIV=1 instance,
// compared cycle by cycle against a per-bit trace built from the frame rules.
`timescale 1ns/1ps
module tb_shift_tx_ctrl;

  localparam int W = 8;
  localparam int D = 4;
`ifdef SHIFT_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int LAT_A = (W + PAR_BITS) * D + 1;
  localparam int LAT_B = (W + PAR_BITS) * 1 + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] din_a = '0, din_b = '0;
  logic       ready_a, busy_a, done_a, so_a;
  logic       ready_b, busy_b, done_b, so_b;

  shift_tx_ctrl #(.WIDTH(W), .DIV(D)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .din(din_a),
    .ready(ready_a), .busy(busy_a), .done(done_a), .so(so_a)
  );

  shift_tx_ctrl #(.WIDTH(W), .DIV(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .din(din_b),
    .ready(ready_b), .busy(busy_b), .done(done_b), .so(so_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected {so, busy, ready, done} for each upcoming cycle.
  logic [3:0] exp_q[$];

  function automatic logic [3:0] obs(input bit sel);
    return sel ? {so_b, busy_b, ready_b, done_b} : {so_a, busy_a, ready_a, done_a};
  endfunction

  task automatic push_frame(input logic [7:0] word, input int div);
    for (int b = 0; b < W; b++)
      for (int k = 0; k < div; k++) exp_q.push_back({word[b], 3'b100});
`ifdef SHIFT_TX_PARITY_EN
    for (int k = 0; k < div; k++) exp_q.push_back({^word, 3'b100});
`endif
    exp_q.push_back(4'b1101);
  endtask

  task automatic push_idle();
    exp_q.push_back(4'b1010);
  endtask

  // Caller sits at a negedge with start/din already driven. Cycle i is sampled at
  // the i-th negedge; the start driven after it is seen at the edge ending cycle i.
  task automatic play(input string tag, input bit sel, input bit hold,
                      input int poke1, input int poke2, input bit rand_din,
                      input logic [7:0] din_fix, output int first_done,
                      output int last_done, output int n_done);
    int         n;
    logic [3:0] e, o;
    logic       st;
    logic [7:0] dv;
    n = exp_q.size();
    first_done = -1;
    last_done  = -1;
    n_done     = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = obs(sel);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: {so,busy,ready,done} got %b expected %b", tag, i, o, e);
      end
      if (o[0] === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = i;
        last_done = i;
      end
      st = (i < n) && (hold || i == poke1 || i == poke2);
      dv = rand_din ? 8'($urandom) : din_fix;
      if (sel) begin start_b = st; din_b = dv; end
      else     begin start_a = st; din_a = dv; end
    end
  endtask

  task automatic expect_int(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (obs(0) !== 4'b1010) begin
      errors++;
      $display("FAIL reset_a: got %b expected 1010", obs(0));
    end
    checks++;
    if (obs(1) !== 4'b1010) begin
      errors++;
      $display("FAIL reset_b: got %b expected 1010", obs(1));
    end
    rst = 1'b0;
  endtask

  task automatic test_frame_a5();
    int fd, ld, nd;
    start_a = 1'b1; din_a = 8'hA5;
    push_frame(8'hA5, D); push_idle();
    play("frame_a5", 0, 0, -1, -1, 1, 8'h00, fd, ld, nd);
    expect_int("frame_a5_done_cycle", fd, LAT_A);
    expect_int("frame_a5_done_count", nd, 1);
  endtask

  task automatic test_parity_07();
    int fd, ld, nd;
    start_a = 1'b1; din_a = 8'h07;
    push_frame(8'h07, D); push_idle();
    play("frame_07", 0, 0, -1, -1, 1, 8'h00, fd, ld, nd);
    expect_int("frame_07_done_cycle", fd, LAT_A);
  endtask

  task automatic test_ignore_start();
    int fd, ld, nd;
    start_a = 1'b1; din_a = 8'h5A;
    push_frame(8'h5A, D); push_idle();
    play("ignore_start", 0, 0, 5, 20, 1, 8'h00, fd, ld, nd);
    expect_int("ignore_start_done_count", nd, 1);
  endtask

  task automatic test_back_to_back();
    int fd, ld, nd;
    start_a = 1'b1; din_a = 8'h01;
    push_frame(8'h01, D); push_idle(); push_frame(8'h80, D); push_idle();
    play("back_to_back", 0, 1, -1, -1, 0, 8'h80, fd, ld, nd);
    expect_int("b2b_first_done", fd, LAT_A);
    expect_int("b2b_second_done", ld, 2 * LAT_A + 1);
    expect_int("b2b_done_count", nd, 2);
  endtask

  task automatic test_reset_mid_frame();
    int fd, ld, nd;
    start_a = 1'b1; din_a = 8'($urandom);
    push_frame(din_a, D);
    while (exp_q.size() > 12) void'(exp_q.pop_back());
    play("pre_abort", 0, 0, -1, -1, 1, 8'h00, fd, ld, nd);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obs(0) !== 4'b1010) begin
      errors++;
      $display("FAIL abort_immediate: got %b expected 1010", obs(0));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs(0) !== 4'b1010) begin
        errors++;
        $display("FAIL abort_hold cycle %0d: got %b expected 1010", i, obs(0));
      end
    end
    rst = 1'b0;
    @(negedge clk);
    start_a = 1'b1; din_a = 8'h3C;
    push_frame(8'h3C, D); push_idle();
    play("after_abort_3c", 0, 0, -1, -1, 1, 8'h00, fd, ld, nd);
    expect_int("after_abort_done_cycle", fd, LAT_A);
  endtask

  task automatic test_random();
    int fd, ld, nd;
    logic [7:0] w;
    for (int f = 0; f < 5; f++) begin
      w = 8'($urandom);
      start_a = 1'b1; din_a = w;
      push_frame(w, D); push_idle();
      play("random_frame", 0, 0, int'($urandom_range(2, LAT_A)),
           int'($urandom_range(2, LAT_A)), 1, 8'h00, fd, ld, nd);
      expect_int("random_done_count", nd, 1);
    end
  endtask

  task automatic test_div1();
    int fd, ld, nd;
    logic [7:0] w;
    start_b = 1'b1; din_b = 8'hFF;
    push_frame(8'hFF, 1); push_idle();
    play("div1_ff", 1, 0, -1, -1, 1, 8'h00, fd, ld, nd);
    expect_int("div1_ff_done_cycle", fd, LAT_B);
    w = 8'($urandom);
    start_b = 1'b1; din_b = w;
    push_frame(w, 1); push_idle();
    play("div1_random", 1, 0, 3, -1, 1, 8'h00, fd, ld, nd);
    expect_int("div1_random_done_count", nd, 1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk);
    test_frame_a5();
    test_parity_07();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_div1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
